skolem_sop_evaluator: RTL

Sequential, parametrised evaluator for synthesised Skolem functions stored as sum-of-products cube tables.
- Software loads one cube table per output at run time.
- The block accepts input-variable assignments over a valid/ready handshake and evaluates the tables one cube index per cycle.
- It returns all output bits over a second handshake.
- It sits downstream of the Skolem-function synthesis flow and lets candidate functions be exercised in hardware without regenerating netlists.

---
 rtl/skolem_eval_pkg.sv | 17 +
 rtl/skolem_cube_bank.sv | 92 +++++++++
 rtl/skolem_sop_evaluator.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/skolem_eval_pkg.sv
// Shared types for the Skolem SOP evaluator: FSM state encoding and the
// cause codes of a rejected configuration access.
package skolem_eval_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

  // Cause of a rejected config access; kept for a future status register.
  localparam logic [1:0] CFG_ERR_NONE = 2'd0;
  localparam logic [1:0] CFG_ERR_BUSY = 2'd1;
  localparam logic [1:0] CFG_ERR_OUT  = 2'd2;
  localparam logic [1:0] CFG_ERR_IDX  = 2'd3;

endpackage

// File: rtl/skolem_cube_bank.sv
// One output's cube table: MAX_CUBES {valid, mask, val} slots, the used-slot
// count and the complement flag, with a combinational hit lookup.
module skolem_cube_bank #(
  parameter int NUM_IN    = 4,
  parameter int MAX_CUBES = 8,
  parameter int CIDX_W    = $clog2(MAX_CUBES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [CIDX_W-1:0] idx_i,
  input  logic [NUM_IN-1:0] mask_i,
  input  logic [NUM_IN-1:0] val_i,
  input  logic              neg_we_i,
  input  logic              neg_i,
  input  logic [CIDX_W-1:0] rd_idx_i,
  input  logic [NUM_IN-1:0] x_i,
  output logic              hit_o,
  output logic [CIDX_W:0]   count_o,
  output logic              neg_o
);

  logic [MAX_CUBES-1:0] valid_q, valid_d;
  logic [NUM_IN-1:0]    mask_q [MAX_CUBES];
  logic [NUM_IN-1:0]    mask_d [MAX_CUBES];
  logic [NUM_IN-1:0]    val_q  [MAX_CUBES];
  logic [NUM_IN-1:0]    val_d  [MAX_CUBES];
  logic [CIDX_W:0]      count_q, count_d;
  logic                 neg_q, neg_d;
  logic [CIDX_W:0]      idx_ext_s;

  assign idx_ext_s = {1'b0, idx_i};

  // Next-state of the table; clear outranks any write in the same cycle
  always_comb begin
    valid_d = valid_q;
    mask_d  = mask_q;
    val_d   = val_q;
    count_d = count_q;
    neg_d   = neg_q;
    if (clr_i) begin
      valid_d = '0;
      count_d = '0;
      neg_d   = 1'b0;
    end else begin
      if (we_i) begin
        valid_d[idx_i] = 1'b1;
        mask_d[idx_i]  = mask_i;
        val_d[idx_i]   = val_i;
        if (idx_ext_s >= count_q) begin
          count_d = idx_ext_s + (CIDX_W+1)'(1);
        end else begin
          count_d = count_q;
        end
      end else begin
        valid_d = valid_q;
      end
      if (neg_we_i) begin
        neg_d = neg_i;
      end else begin
        neg_d = neg_q;
      end
    end
  end

  // Table storage register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
      neg_q   <= 1'b0;
      for (int i = 0; i < MAX_CUBES; i++) begin
        mask_q[i] <= '0;
        val_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      neg_q   <= neg_d;
      mask_q  <= mask_d;
      val_q   <= val_d;
    end
  end

  // An unwritten slot never hits, even though its reset mask is all-don't-care
  assign hit_o   = valid_q[rd_idx_i] &&
                   (((x_i ^ val_q[rd_idx_i]) & mask_q[rd_idx_i]) == '0);
  assign count_o = count_q;
  assign neg_o   = neg_q;

endmodule

// File: rtl/skolem_sop_evaluator.sv
// Sequential evaluator of run-time loaded sum-of-products Skolem functions:
// one cube index per cycle across all outputs, results over a valid/ready port.
module skolem_sop_evaluator
  import skolem_eval_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int NUM_OUT   = 1,
  parameter int MAX_CUBES = 8,
  parameter int CIDX_W    = $clog2(MAX_CUBES),
  parameter int OIDX_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [OIDX_W-1:0]  cfg_out,
  input  logic [CIDX_W-1:0]  cfg_idx,
  input  logic [NUM_IN-1:0]  cfg_mask,
  input  logic [NUM_IN-1:0]  cfg_val,
  input  logic               cfg_neg_we,
  input  logic               cfg_neg,
  input  logic               cfg_clear,
  output logic               cfg_err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_IN-1:0]  in_x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_y,
  output logic               busy
);

  state_e               state_q, state_d;
  logic [CIDX_W-1:0]    idx_q, idx_d;
  logic [CIDX_W:0]      maxc_q, maxc_d;
  logic [NUM_IN-1:0]    x_q, x_d;
  logic [NUM_OUT-1:0]   acc_q, acc_d;
  logic [NUM_OUT-1:0]   out_y_q, out_y_d;
  logic                 out_valid_q, out_valid_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 cfg_any_s;
  logic                 out_bad_s;
  logic                 idx_bad_s;
  logic [1:0]           cfg_cause_s;
  logic                 cfg_ok_s;
  logic                 bank_clr_s;
  logic [NUM_OUT-1:0]   bank_we_s;
  logic [NUM_OUT-1:0]   bank_neg_we_s;
  logic [NUM_OUT-1:0]   hit_s;
  logic [NUM_OUT-1:0]   neg_s;
  logic [CIDX_W:0]      count_s [NUM_OUT];
  logic [CIDX_W:0]      maxc_s;
  logic                 in_ready_s;

  assign cfg_any_s = cfg_we | cfg_neg_we | cfg_clear;
  assign out_bad_s = ({1'b0, cfg_out} >= (OIDX_W+1)'(NUM_OUT));
  assign idx_bad_s = ({1'b0, cfg_idx} >= (CIDX_W+1)'(MAX_CUBES));

  // Classify the config access; anything outside IDLE is refused
  always_comb begin
    cfg_cause_s = CFG_ERR_NONE;
    if (!cfg_any_s) begin
      cfg_cause_s = CFG_ERR_NONE;
    end else if (state_q != IDLE) begin
      cfg_cause_s = CFG_ERR_BUSY;
    end else if (cfg_clear) begin
      cfg_cause_s = CFG_ERR_NONE;
    end else if (out_bad_s) begin
      cfg_cause_s = CFG_ERR_OUT;
    end else if (cfg_we && idx_bad_s) begin
      cfg_cause_s = CFG_ERR_IDX;
    end else begin
      cfg_cause_s = CFG_ERR_NONE;
    end
  end

  assign cfg_ok_s   = cfg_any_s && (cfg_cause_s == CFG_ERR_NONE);
  assign cfg_err_d  = cfg_any_s && (cfg_cause_s != CFG_ERR_NONE);
  assign bank_clr_s = cfg_ok_s && cfg_clear;

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_bank
    assign bank_we_s[j]     = cfg_ok_s && !cfg_clear && cfg_we &&
                              (cfg_out == OIDX_W'(j));
    assign bank_neg_we_s[j] = cfg_ok_s && !cfg_clear && cfg_neg_we &&
                              (cfg_out == OIDX_W'(j));

    skolem_cube_bank #(
      .NUM_IN    (NUM_IN),
      .MAX_CUBES (MAX_CUBES),
      .CIDX_W    (CIDX_W)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (bank_clr_s),
      .we_i     (bank_we_s[j]),
      .idx_i    (cfg_idx),
      .mask_i   (cfg_mask),
      .val_i    (cfg_val),
      .neg_we_i (bank_neg_we_s[j]),
      .neg_i    (cfg_neg),
      .rd_idx_i (idx_q),
      .x_i      (x_q),
      .hit_o    (hit_s[j]),
      .count_o  (count_s[j]),
      .neg_o    (neg_s[j])
    );
  end

  // Longest table sets how many cube indices one evaluation has to scan
  always_comb begin
    maxc_s = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      if (count_s[j] > maxc_s) begin
        maxc_s = count_s[j];
      end else begin
        maxc_s = maxc_s;
      end
    end
  end

  assign in_ready_s = rst_n && (state_q == IDLE) && !cfg_any_s;

  // FSM next-state plus idx/acc/result datapath
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    maxc_d      = maxc_q;
    x_d         = x_q;
    acc_d       = acc_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_s) begin
          x_d    = in_x;
          maxc_d = maxc_s;
          acc_d  = '0;
          idx_d  = '0;
          if (maxc_s == '0) begin
            state_d = DONE;
          end else begin
            state_d = EVAL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EVAL: begin
        acc_d = acc_q | hit_s;
        idx_d = idx_q + CIDX_W'(1);
        if ({1'b0, idx_q} == (maxc_q - (CIDX_W+1)'(1))) begin
          state_d = DONE;
        end else begin
          state_d = EVAL;
        end
      end
      DONE: begin
        out_y_d     = neg_s ^ acc_q;
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Control and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      maxc_q      <= '0;
      x_q         <= '0;
      acc_q       <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      maxc_q      <= maxc_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q == EVAL) || (state_q == DONE);

endmodule
